pipeline: RTL and testbench
===========================

// Module: pipeline
// PURPOSE
//   Unsigned WIDTH x WIDTH multiplier (default 4x4 -> 8-bit), pipelined as
//   three register stages. Accepts one new operand pair every clock and
//   returns one product every clock after a fixed latency.
//   Used as a throughput arithmetic block. No handshake: every clock is a
//   valid issue slot.
// PARAMETERS
//   WIDTH  4  operand width in bits; result is 2*WIDTH bits
// PORTS
//   clk     input   1        rising-edge clock; the only clock
//   rst_n   input   1        reset; synchronous, ACTIVE-HIGH (1 = reset)
//   data_a  input   WIDTH    unsigned multiplicand
//   data_b  input   WIDTH    unsigned multiplier
//   result  output  2*WIDTH  registered unsigned product data_a*data_b
// BEHAVIOUR
//   Reset
//     - rst_n is sampled only at posedge clk.
//     - While rst_n==1 at an edge, all stage registers and result load 0.
//     - No async path.
//   Stage 1 (edge k)
//     - Register data_a and data_b into a_s1 and b_s1.
//   Stage 2 (edge k+1)
//     - Partial products pp_i = b_s1[i] ? (a_s1 << i) : 0, for i = 0..WIDTH-1.
//     - Sum the partial products pairwise into 2*WIDTH-bit registers.
//     - Default: s2_lo = pp0+pp1 and s2_hi = pp2+pp3.
//   Stage 3 (edge k+2)
//     - result <= s2_lo + s2_hi. The adder tree is generalised for other WIDTH.
//   Latency and throughput
//     - Latency is 3 clocks: result after edge k+2 equals the product of the
//       operands sampled at edge k. It holds until edge k+3.
//     - Throughput is 1 product per clock. Back-to-back operands never stall or mix.
//   Arithmetic
//     - Unsigned throughout. Intermediate sums are 2*WIDTH bits wide.
//     - Maximum is 15*15=225, which fits in 8 bits, so there is no overflow
//       and no truncation.
//   Boundaries
//     - Operand 0 on either input gives product 0.
//     - All-ones operands give (2^WIDTH-1)^2.
//     - Operands may change every cycle. Inputs held constant produce a
//       constant result after latency.
//   Reset mid-operation
//     - Flushes every in-flight product; none appears after reset.
//     - After rst_n returns to 0, result stays 0 until the first post-reset
//       operands emerge 3 clocks later.
//   Simultaneous reset and input
//     - Reset wins. Operands presented on a reset edge are discarded.
//   No X on result after the first reset edge.
// TESTING
//   1. Hold rst_n=1 for 2 clocks with a=5, b=7 -> result==0 throughout and
//      for 3 clocks after release (until the first post-reset sample emerges).
//   2. Release reset, stream pairs (1,1),(2,2)...(9,9) one per clock ->
//      results 1,4,9,16,25,36,49,64,81 on consecutive clocks, each 3 clocks
//      after its issue.
//   3. Corners a=15,b=15 -> 225; a=15,b=0 -> 0; a=0,b=15 -> 0;
//      a=1,b=15 -> 15; a=8,b=2 -> 16.
//   4. Hold a=12, b=11 for 6 clocks -> result reaches 132 after latency and
//      stays 132.
//   5. Stream (3,4),(6,7),(9,9), then assert rst_n on the edge issuing (9,9)
//      -> result 0 next clock. Neither 42 nor 81 ever appears.
//   6. Random 1000 pairs vs reference model delayed 3 clocks -> exact match
//      every cycle.

Source files
------------

// File: rtl/pipeline.sv
// Unsigned WIDTH x WIDTH multiplier pipelined over three register stages.
// One operand pair is accepted every clock; its product appears on result
// three clocks later.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous reset, active high (1 = reset)
//   data_a - unsigned multiplicand, WIDTH bits
//   data_b - unsigned multiplier, WIDTH bits
//   result - registered product, 2*WIDTH bits
module pipeline #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     data_a,
  input  logic [WIDTH-1:0]     data_b,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned RW   = 2 * WIDTH;
  localparam int unsigned HALF = WIDTH / 2;

  logic [WIDTH-1:0] a_s1_q, a_s1_d;
  logic [WIDTH-1:0] b_s1_q, b_s1_d;
  logic [RW-1:0]    s2_lo_q, s2_lo_d;
  logic [RW-1:0]    s2_hi_q, s2_hi_d;
  logic [RW-1:0]    result_q, result_d;

  // Next-state logic for all three stages
  always_comb begin
    a_s1_d   = data_a;
    b_s1_d   = data_b;
    s2_lo_d  = '0;
    s2_hi_d  = '0;
    // Lower half of the partial products feeds s2_lo, upper half feeds s2_hi
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (b_s1_q[i]) begin
        if (i < HALF) begin
          s2_lo_d = s2_lo_d + (RW'(a_s1_q) << i);
        end else begin
          s2_hi_d = s2_hi_d + (RW'(a_s1_q) << i);
        end
      end
    end
    result_d = s2_lo_q + s2_hi_q;
  end

  // Stage registers; reset flushes everything in flight
  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_s1_q   <= '0;
      b_s1_q   <= '0;
      s2_lo_q  <= '0;
      s2_hi_q  <= '0;
      result_q <= '0;
    end else begin
      a_s1_q   <= a_s1_d;
      b_s1_q   <= b_s1_d;
      s2_lo_q  <= s2_lo_d;
      s2_hi_q  <= s2_hi_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_pipeline.sv
// Directed and random checks of the three-stage pipelined 4x4 multiplier.
module tb_pipeline;

  logic       clk;
  logic       rst_n;
  logic [3:0] data_a;
  logic [3:0] data_b;
  logic [7:0] result;

  int n_checks;
  int n_pass;

  pipeline #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_a (data_a),
    .data_b (data_b),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d (%b) expected %0d", tag, got, got, exp);
    end
  endtask

  // Present operands and reset for the next edge, then step past that edge
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic r);
    data_a = a;
    data_b = b;
    rst_n  = r;
    @(posedge clk);
    #1;
  endtask

  int unsigned sq_exp [9]  = '{1, 4, 9, 16, 25, 36, 49, 64, 81};
  logic [3:0]  ca [5]      = '{15, 15, 0, 1, 8};
  logic [3:0]  cb [5]      = '{15, 0, 15, 15, 2};
  int unsigned c_exp [5]   = '{225, 0, 0, 15, 16};
  int unsigned prod_q [$];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    data_a   = '0;
    data_b   = '0;
    rst_n    = 1'b1;

    // Reset held with non-zero operands
    issue(4'd5, 4'd7, 1'b1);
    check("reset_hold0", result, 8'd0);
    issue(4'd5, 4'd7, 1'b1);
    check("reset_hold1", result, 8'd0);
    // Release: (5,7) sampled now, emerges after the third edge
    issue(4'd5, 4'd7, 1'b0);
    check("post_rel0", result, 8'd0);
    issue(4'd5, 4'd7, 1'b0);
    check("post_rel1", result, 8'd0);

    // Stream squares 1..9 back to back, then two pad issues
    for (int j = 0; j < 11; j++) begin
      if (j < 9) issue(4'(j + 1), 4'(j + 1), 1'b0);
      else       issue(4'd0, 4'd0, 1'b0);
      if (j == 0) check("first_35", result, 8'd35);
      if (j >= 2) check($sformatf("square%0d", j - 1), result, 8'(sq_exp[j-2]));
    end

    // Corner operands
    for (int j = 0; j < 7; j++) begin
      if (j < 5) issue(ca[j], cb[j], 1'b0);
      else       issue(4'd0, 4'd0, 1'b0);
      if (j >= 2) check($sformatf("corner%0d", j - 2), result, 8'(c_exp[j-2]));
    end

    // Constant inputs give a constant result
    for (int j = 0; j < 6; j++) begin
      issue(4'd12, 4'd11, 1'b0);
      if (j >= 2) check($sformatf("hold132_%0d", j), result, 8'd132);
    end

    // Reset on the edge issuing (9,9) flushes (3,4) and (6,7) too
    issue(4'd3, 4'd4, 1'b0);
    issue(4'd6, 4'd7, 1'b0);
    issue(4'd9, 4'd9, 1'b1);
    check("flush_rst", result, 8'd0);
    for (int j = 0; j < 4; j++) begin
      issue(4'd0, 4'd0, 1'b0);
      check($sformatf("flush_after%0d", j), result, 8'd0);
    end

    // Random stream against a 3-deep delayed reference
    prod_q.delete();
    for (int j = 0; j < 1000; j++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      ra = 4'($urandom_range(15));
      rb = 4'($urandom_range(15));
      issue(ra, rb, 1'b0);
      prod_q.push_back(int'(ra) * int'(rb));
      if (prod_q.size() >= 3) begin
        check("random", result, 8'(prod_q[prod_q.size() - 3]));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
